// File: rtl/display_pkg.sv
// Shared types and constants for the seven-segment display blocks.
// Digits are 4-bit nibbles packed eight to a 32-bit value, digit 0 in the LSBs.
package display_pkg;

  localparam int N_DIGITS = 8;
  localparam int DIGIT_W  = 4;
  localparam int VALUE_W  = N_DIGITS * DIGIT_W;

  typedef logic [2:0] digit_idx_t;

  typedef enum logic {
    SHOW  = 1'b0,
    GUARD = 1'b1
  } scan_state_e;

endpackage

// File: rtl/display_scan_controller_lead_zero_mask.sv
// Leading-zero mask: bit k is set when digit k and every digit above it are zero.
// Digit 0 is never masked so a zero value still shows a single "0".
module lead_zero_mask
  import display_pkg::*;
(
  input  logic [VALUE_W-1:0]  value,
  input  logic                unused_tie,
  output logic [N_DIGITS-1:0] mask
);

  logic unused_s;
  assign unused_s = unused_tie;

  assign mask[0] = 1'b0;

  for (genvar k = 1; k < N_DIGITS; k++) begin : g_mask
    assign mask[k] = ~|value[VALUE_W-1:k*DIGIT_W];
  end

endmodule

// File: rtl/display_scan_controller.sv
// Eight-digit multiplex scan sequencer with anode-off guard slots between digits,
// a frame-aligned shadow of the displayed value and leading-zero / per-digit blanking.
module display_scan_controller
  import display_pkg::*;
#(
  parameter int DIGIT_TICKS = 100_000,
  parameter int BLANK_TICKS = 1_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] value_in,
  input  logic        update,
  input  logic [7:0]  digit_en,
  input  logic        lz_blank,
  output logic [31:0] value_out,
  output logic [2:0]  counter,
  output logic        blank,
  output logic        update_pending,
  output logic        frame_done
);

  localparam int MAX_TICKS = (DIGIT_TICKS > BLANK_TICKS) ? DIGIT_TICKS : BLANK_TICKS;
  localparam int TICK_W    = (MAX_TICKS > 1) ? $clog2(MAX_TICKS) : 1;

  localparam logic [TICK_W-1:0] DIGIT_LAST = TICK_W'(DIGIT_TICKS - 1);
  localparam logic [TICK_W-1:0] BLANK_LAST = TICK_W'(BLANK_TICKS - 1);
  localparam logic [TICK_W-1:0] TICK_ZERO  = {TICK_W{1'b0}};
  localparam logic [TICK_W-1:0] TICK_ONE   = TICK_W'(1);
  localparam digit_idx_t        LAST_DIGIT = 3'd7;

  scan_state_e         state_r;
  logic [TICK_W-1:0]   tick_r;
  logic [VALUE_W-1:0]  pending_val_r;
  logic [N_DIGITS-1:0] lz_mask_r;

  logic                boundary_s;
  logic [VALUE_W-1:0]  next_value_s;
  logic [N_DIGITS-1:0] next_mask_s;

  // The frame ends on the final guard slot that follows digit 7.
  assign boundary_s = (state_r == GUARD) && (tick_r == BLANK_LAST) && (counter == LAST_DIGIT);

  // Value that the shadow register takes at the boundary; a same-cycle update wins over a queued one.
  always_comb begin
    next_value_s = value_out;
    if (update) begin
      next_value_s = value_in;
    end else if (update_pending) begin
      next_value_s = pending_val_r;
    end else begin
      next_value_s = value_out;
    end
  end

  lead_zero_mask u_lead_zero_mask (
    .value      (next_value_s),
    .unused_tie (1'b0),
    .mask       (next_mask_s)
  );

  // Anodes stay off during guard slots; while showing, digit_en and lz_blank act live.
  always_comb begin
    blank = 1'b1;
    case (state_r)
      SHOW:    blank = ~(digit_en[counter] & ~(lz_blank & lz_mask_r[counter]));
      GUARD:   blank = 1'b1;
      default: blank = 1'b1;
    endcase
  end

  // Scan FSM, tick prescaler and frame-aligned shadow registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r        <= GUARD;
      tick_r         <= TICK_ZERO;
      counter        <= LAST_DIGIT;
      value_out      <= 32'h0000_0000;
      pending_val_r  <= 32'h0000_0000;
      update_pending <= 1'b0;
      frame_done     <= 1'b0;
      lz_mask_r      <= 8'hFE;
    end else begin
      frame_done <= boundary_s;

      case (state_r)
        SHOW: begin
          if (tick_r == DIGIT_LAST) begin
            state_r <= GUARD;
            tick_r  <= TICK_ZERO;
          end else begin
            tick_r <= tick_r + TICK_ONE;
          end
        end
        GUARD: begin
          if (tick_r == BLANK_LAST) begin
            state_r <= SHOW;
            tick_r  <= TICK_ZERO;
            counter <= counter + 3'd1;
          end else begin
            tick_r <= tick_r + TICK_ONE;
          end
        end
        default: begin
          state_r <= GUARD;
          tick_r  <= TICK_ZERO;
        end
      endcase

      // Updates outside the boundary queue up (last one wins) until the next frame.
      if (boundary_s) begin
        value_out      <= next_value_s;
        lz_mask_r      <= next_mask_s;
        update_pending <= 1'b0;
      end else if (update) begin
        pending_val_r  <= value_in;
        update_pending <= 1'b1;
      end else begin
        update_pending <= update_pending;
      end
    end
  end

endmodule

// File: doc/display_scan_controller.md
Name: display_scan_controller

Overview:
- Sequences the 8-digit seven-segment multiplexer.
- Generates its 3-bit digit-select counter at a programmable refresh rate and inserts an all-anodes-off guard interval between digits to suppress ghosting.
- Holds a tear-free shadow copy of the displayed value, updated only at frame boundaries, and applies per-digit enable and leading-zero blanking.
- Sits between the application logic and the digit multiplexer. The top level forces all anodes high while `blank`=1.

Parameters:
- DIGIT_TICKS, 100_000, clk cycles each digit is lit (1 ms at 100 MHz); must be >= 1.
- BLANK_TICKS, 1_000, clk cycles of guard (all anodes off) between digits; must be >= 1.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- value_in  in  32  eight 4-bit digits; nibble k (bits 4k+3:4k) is digit k
- update  in  1  single-cycle strobe; requests that value_in be displayed from the next frame
- digit_en  in  8  per-digit enable; 0 = digit k always blank
- lz_blank  in  1  1 = suppress leading zeros
- value_out  out  32  shadow value driving mux inputs dig0..dig7 (nibble k -> digk)
- counter  out  3  digit select to the multiplexer
- blank  out  1  1 = all anodes must be off this cycle
- update_pending  out  1  an accepted update is waiting for the frame boundary
- frame_done  out  1  one-cycle pulse at every frame boundary

Behaviour:
- Reset values (async): state=GUARD, counter=7, tick=0, value_out=0, pending_val=0, update_pending=0, frame_done=0, blank=1, lz_mask=8'hFE.
- FSM states:
  - SHOW: counter held, tick counts 0..DIGIT_TICKS-1. On the last tick, go to GUARD with tick=0.
  - GUARD: blank=1, tick counts 0..BLANK_TICKS-1. On the last tick, counter <= counter+1 (wraps 7->0), go to SHOW with tick=0.
- In SHOW: blank = ~(digit_en[counter] & ~(lz_blank & lz_mask[counter])). blank is combinational from registered state and inputs.
- Frame boundary: the last GUARD cycle while counter==7. In that same clock edge:
  - frame_done <= 1 for exactly one cycle.
  - If update is high this cycle: value_out <= value_in.
  - Else if update_pending: value_out <= pending_val.
  - update_pending <= 0.
  - lz_mask <= lead-zero mask of the newly loaded value_out, or of the unchanged value when nothing loads.
- Lead-zero mask rules:
  - Bit k=1 iff k>=1 and nibbles k..7 are all zero.
  - Bit 0 is always 0, so digit 0 always shows. Value 0 shows a single "0".
- update outside the boundary cycle: pending_val <= value_in, update_pending <= 1. Repeated updates overwrite (last wins).
- value_out never changes except at a frame boundary or reset.
- Reset start-up: the first boundary occurs BLANK_TICKS cycles after reset release. counter becomes 0 and frame_done pulses then.
- Frame period: 8*(DIGIT_TICKS+BLANK_TICKS) cycles.
- Reset mid-frame: all state returns to reset values immediately; pending update is lost.
- digit_en and lz_blank are sampled live, with no frame alignment.
- Counter widths: $clog2(max(DIGIT_TICKS,BLANK_TICKS)) bits; no overflow beyond terminal count.

Decomposition:
- Package display_pkg holds:
  - state enum {SHOW, GUARD}
  - N_DIGITS=8
  - DIGIT_W=4
  - the 3-bit digit index typedef
- One combinational sub-module, lead_zero_mask: 32-bit value in, 8-bit mask out. It is also reused by future display blocks.
- The FSM, prescaler and shadow registers live in display_scan_controller.

Test Plan (DIGIT_TICKS=4, BLANK_TICKS=2; frame = 48 cycles):
- Reset release, digit_en=FF, lz_blank=0:
  - frame_done pulses at cycle 2.
  - counter then steps 0..7, each index held 6 cycles.
  - blank=1 exactly 2 cycles before each increment.
  - frame_done repeats every 48 cycles.
- update with value_in=32'h1234_5678 mid-frame:
  - update_pending=1.
  - value_out stays 0 until the boundary, then becomes 32'h12345678.
  - update_pending clears and frame_done pulses in the same cycle.
- Two updates in one frame (32'hAAAA_AAAA, then 32'h0000_00FF) -> only 32'h000000FF is loaded at the boundary.
- update asserted on the exact boundary cycle with 32'hDEAD_BEEF -> value_out=32'hDEADBEEF next cycle; update_pending stays 0.
- lz_blank=1, value 32'h0000_0305:
  - blank=1 for the whole SHOW of counter 3..7.
  - Digits 0..2 are lit, including the inner zero at digit 1.
  - Value 0 -> only digit 0 is lit.
- digit_en=8'b1010_1010 -> blank=1 during SHOW of even digits. Then assert reset mid-SHOW -> counter=7, blank=1 and value_out=0 asynchronously, before the next clk edge.
